// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back stage and the
// general-purpose register file.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef enum logic {
        RF_SEL_ALU = 1'b0,
        RF_SEL_MEM = 1'b1
    } rf_dsel_t;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    // True when idx names a physical register (matters only if NUM_REGS < 2**ADDR_W)
    function automatic logic idx_in_range(reg_idx_t idx);
        return ({{(32-ADDR_W){1'b0}}, idx} < 32'(NUM_REGS));
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, decode read ports and
// the forwarding/commit outputs.
interface wb_regfile_if;
    import wb_pkg::*;

    logic [DATA_W-1:0] WB_ALU_RES;
    logic [DATA_W-1:0] WB_DM_Q;
    logic              WB_RF_D_SEL;
    logic              WB_RF_WE;
    reg_idx_t          WB_RD;
    reg_idx_t          ID_RS;
    reg_idx_t          ID_RT;
    logic [DATA_W-1:0] ID_RS_DATA;
    logic [DATA_W-1:0] ID_RT_DATA;
    logic [DATA_W-1:0] WB_DATA;
    logic              WB_COMMIT;

    modport master (
        output WB_ALU_RES, WB_DM_Q, WB_RF_D_SEL, WB_RF_WE, WB_RD, ID_RS, ID_RT,
        input  ID_RS_DATA, ID_RT_DATA, WB_DATA, WB_COMMIT
    );

    modport slave (
        input  WB_ALU_RES, WB_DM_Q, WB_RF_D_SEL, WB_RF_WE, WB_RD, ID_RS, ID_RT,
        output ID_RS_DATA, ID_RT_DATA, WB_DATA, WB_COMMIT
    );

endinterface

// File: rtl/wb_regfile_mux.sv
// Write-back data select: ALU result or data-memory read data, full width.
module wb_mux
    import wb_pkg::*;
(
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] dm_q,
    input  rf_dsel_t          sel,
    output logic [DATA_W-1:0] wb_data
);

    // 2:1 select of the value to be written back
    always_comb begin
        wb_data = alu_res;
        case (sel)
            RF_SEL_ALU: wb_data = alu_res;
            RF_SEL_MEM: wb_data = dm_q;
            default:    wb_data = alu_res;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back commit into a 32x32 register file with two decode read ports
// that see the value being written in the same cycle.
module wb_regfile
    import wb_pkg::*;
#(
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] wb_data_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    rf_dsel_t          dsel_s;
    logic              wr_ok_s;
    logic              commit_r;

    assign dsel_s = rf_dsel_t'(bus.WB_RF_D_SEL);

    wb_mux u_mux (
        .alu_res (bus.WB_ALU_RES),
        .dm_q    (bus.WB_DM_Q),
        .sel     (dsel_s),
        .wb_data (wb_data_s)
    );

    assign bus.WB_DATA    = wb_data_s;
    assign bus.ID_RS_DATA = rs_data_s;
    assign bus.ID_RT_DATA = rt_data_s;
    assign bus.WB_COMMIT  = commit_r;

    // Commit qualifier; also gates bypass, so reset hides the in-flight write
    always_comb begin
        wr_ok_s = 1'b0;
        if (bus.WB_RF_WE && !rst && idx_in_range(bus.WB_RD) &&
            !(ZERO_REG_EN && (bus.WB_RD == {ADDR_W{1'b0}}))) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Read port A: zero register, then same-cycle bypass, then array
    always_comb begin
        rs_data_s = {DATA_W{1'b0}};
        if (ZERO_REG_EN && (bus.ID_RS == {ADDR_W{1'b0}})) begin
            rs_data_s = {DATA_W{1'b0}};
        end else if (wr_ok_s && (bus.ID_RS == bus.WB_RD)) begin
            rs_data_s = wb_data_s;
        end else if (idx_in_range(bus.ID_RS)) begin
            rs_data_s = regs_r[bus.ID_RS];
        end else begin
            rs_data_s = {DATA_W{1'b0}};
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        rt_data_s = {DATA_W{1'b0}};
        if (ZERO_REG_EN && (bus.ID_RT == {ADDR_W{1'b0}})) begin
            rt_data_s = {DATA_W{1'b0}};
        end else if (wr_ok_s && (bus.ID_RT == bus.WB_RD)) begin
            rt_data_s = wb_data_s;
        end else if (idx_in_range(bus.ID_RT)) begin
            rt_data_s = regs_r[bus.ID_RT];
        end else begin
            rt_data_s = {DATA_W{1'b0}};
        end
    end

    // Register array update and commit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            commit_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                regs_r[bus.WB_RD] <= wb_data_s;
            end
            commit_r <= wr_ok_s;
        end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface.
- Consumes the WB-stage signals (ALU result, data-memory read data, data-select, write enable, destination register) and selects the write-back value.
- Commits that value into a 32x32 general-purpose register file.
- Serves two decode-stage read ports with same-cycle WB-to-ID bypass, so the decode stage sees the value being written this cycle.

Parameters:
- DATA_W, 32, register and datapath width.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width (log2 NUM_REGS).
- ZERO_REG_EN, 1, when 1, register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- WB_ALU_RES  in  DATA_W  ALU result from the MEM/WB register.
- WB_DM_Q  in  DATA_W  data-memory read data from the MEM/WB register.
- WB_RF_D_SEL  in  1  write-data select: 0 = WB_ALU_RES, 1 = WB_DM_Q.
- WB_RF_WE  in  1  register-file write enable for the instruction in WB.
- WB_RD  in  ADDR_W  destination register index.
- ID_RS  in  ADDR_W  read port A index.
- ID_RT  in  ADDR_W  read port B index.
- ID_RS_DATA  out  DATA_W  read port A data.
- ID_RT_DATA  out  DATA_W  read port B data.
- WB_DATA  out  DATA_W  selected write-back value (for EX forwarding).
- WB_COMMIT  out  1  registered pulse: a write committed on the previous edge.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Write-back mux (combinational):
  - WB_DATA = WB_RF_D_SEL ? WB_DM_Q : WB_ALU_RES.
  - Full width, no extension or truncation.
- Commit condition: wr_ok = WB_RF_WE & ~rst & ~(ZERO_REG_EN & WB_RD==0).
- Commit: on posedge clk with wr_ok, regs[WB_RD] <= WB_DATA.
- Write latency: value is architecturally visible in the array one edge after presentation; it is visible on the read ports in the same cycle via bypass.
- Read ports (combinational, per port p with index IDX):
  - If ZERO_REG_EN and IDX==0: 0.
  - Else if wr_ok and IDX==WB_RD: WB_DATA (bypass).
  - Else: regs[IDX].
- Simultaneous events:
  - Both read ports equal to WB_RD: both are bypassed.
  - ID_RS==ID_RT: identical outputs.
- WB_COMMIT:
  - Registered: WB_COMMIT <= wr_ok each edge.
  - Reset value 0; high for exactly one cycle per committed write.
- Reset:
  - When rst is high at a posedge, all NUM_REGS entries clear to 0 and WB_COMMIT clears to 0.
  - Any write presented in that cycle is dropped, and bypass is disabled while rst is high, so the read ports return array contents, which are 0 after the first reset edge.
  - Reset asserted mid-stream discards the in-flight WB write; no partial commit.
- Reset values of outputs:
  - ID_RS_DATA, ID_RT_DATA and WB_DATA are combinational; they are 0 after reset only when the inputs and selectors produce 0.
  - WB_COMMIT = 0.
- Write index outside NUM_REGS (only when NUM_REGS < 2**ADDR_W): the write is ignored, and reads of such an index return 0.
- X-safety: WB_RF_WE must not be X after reset; the verification environment asserts this.

Decomposition:
- Package wb_pkg holds:
  - constants DATA_W, ADDR_W, NUM_REGS;
  - typedef enum logic {RF_SEL_ALU=0, RF_SEL_MEM=1} rf_dsel_t;
  - typedef logic [ADDR_W-1:0] reg_idx_t.
- One natural sub-module: wb_mux, the 2:1 write-back select producing WB_DATA.
- Array, bypass and read ports stay in wb_regfile.

Test Plan:
- Reset clear: preload regs[5]=0xDEADBEEF, assert rst one cycle -> ID_RS=5 reads 0x00000000; WB_COMMIT=0.
- Mux select:
  - WB_ALU_RES=0x11111111, WB_DM_Q=0x22222222, WB_RF_D_SEL=0, WE=1, RD=3 -> next cycle ID_RS=3 reads 0x11111111.
  - Repeat with SEL=1 -> reads 0x22222222.
- Bypass: WE=1, RD=7, WB_DATA=0xCAFEF00D, ID_RS=ID_RT=7 in the same cycle -> both outputs equal 0xCAFEF00D before the edge; after the edge they still read 0xCAFEF00D from the array.
- Zero register: WE=1, RD=0, data 0xFFFFFFFF -> ID_RS=0 reads 0 in the same cycle and after; WB_COMMIT stays 0.
- Reset mid-write: WE=1, RD=9, data 0x12345678 with rst=1 in the same cycle -> regs[9]=0, no bypass during that cycle, WB_COMMIT=0 next cycle.
- Back-to-back: writes RD=4 with 0xA then RD=4 with 0xB on consecutive cycles -> WB_COMMIT high for 2 cycles; ID_RS=4 reads 0xA in cycle 1 (bypass) and 0xB in cycle 2 (bypass overrides the stale array value).
